mem_arbiter: RTL

Shares the single external memory port between instruction fetch (IF) and the MEM stage of the 5-stage RISC-V core, and generates the pipeline stall vector `stall[5:0]` consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences each memory access as a req/ack transaction, returns read data with a one-cycle done pulse, and folds in stall requests from ID and EX.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the
// MEM stage, and builds the six-bit pipeline stall vector.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    output logic [5:0]        stall
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM,
        RESP_IF,
        RESP_MEM
    } state_e;

    state_e              state_q, state_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]          bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d     = BUSY_MEM;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = 4'b1111;
                end
            end
            BUSY_IF: begin
                if (bus_ack) begin
                    state_d    = RESP_IF;
                    if_rdata_d = bus_rdata;
                end
            end
            BUSY_MEM: begin
                if (bus_ack) begin
                    state_d     = RESP_MEM;
                    mem_rdata_d = bus_rdata;
                end
            end
            // The pipeline consumes the result on the edge leaving RESP, so the
            // still-asserted request must not be sampled here.
            RESP_IF, RESP_MEM: state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the
        // pre-edge value of the others, independent of statement order.
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_req   = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = (state_q == RESP_IF);
    assign mem_done  = (state_q == RESP_MEM);

    // Deeper stages win: a pending load/store also bubbles WB.
    always_comb begin
        stall = 6'b000000;
        if (!rst_n)                     stall = 6'b000000;
        else if (mem_req && !mem_done)  stall = 6'b011111;
        else if (stallreq_ex)           stall = 6'b001111;
        else if (stallreq_id)           stall = 6'b000111;
        else if (if_req && !if_done)    stall = 6'b000011;
    end

endmodule
